fnd_scan_decoder: RTL and testbench

- Receive-side counterpart of the 4-digit FND scan driver.
- Samples the multiplexed com/seg_7 drive, decodes each lit digit's segment pattern back into a hex nibble, and reassembles the 16-bit value word.
- Used as an on-chip monitor and verification probe beside the FND controller in the multi-function clock.
- Publishes one complete frame per scan cycle, with error and stall flags.

---
 rtl/fnd_pkg.sv | 38 +++
 rtl/seg7_pattern_decode.sv | 22 ++
 rtl/fnd_scan_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared seven-segment table, FSM states and com helper for the FND scan path
package fnd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g patterns indexed by hex digit; the FND driver encodes from the same table.
    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } fnd_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } com_sel_t;

    // Anything other than exactly one low bit is a blanking gap between digits.
    function automatic com_sel_t decode_com(input logic [3:0] com);
        com_sel_t r;
        r.valid = 1'b0;
        r.idx   = 2'd0;
        case (com)
            4'b1110: begin r.valid = 1'b1; r.idx = 2'd0; end
            4'b1101: begin r.valid = 1'b1; r.idx = 2'd1; end
            4'b1011: begin r.valid = 1'b1; r.idx = 2'd2; end
            4'b0111: begin r.valid = 1'b1; r.idx = 2'd3; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational active-low segment pattern to hex nibble decoder
module seg7_pattern_decode
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    // Unknown patterns, blank included, decode to 0 with the error flag raised.
    always_comb begin
        nibble = 4'd0;
        err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_PATTERN[i]) begin
                nibble = 4'(i);
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - recovers the 16-bit value from a multiplexed 4-digit FND com/seg drive
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [3:0]  com,
    input  logic [7:0]  seg_7,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  digit_err,
    output logic        changed,
    output logic        scan_stall
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    logic [3:0] com_s;
    logic [6:0] seg_s;
    logic       unused_dp;

    assign unused_dp = seg_7[7];

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign com_s = com;
            assign seg_s = seg_7[6:0];
        end else begin : g_sync
            logic [3:0] com_pipe_q [SYNC_STAGES];
            logic [6:0] seg_pipe_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_p) begin
                if (!reset_p) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        com_pipe_q[i] <= 4'hF;
                        seg_pipe_q[i] <= SEG_BLANK;
                    end
                end else begin
                    com_pipe_q[0] <= com;
                    seg_pipe_q[0] <= seg_7[6:0];
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        com_pipe_q[i] <= com_pipe_q[i-1];
                        seg_pipe_q[i] <= seg_pipe_q[i-1];
                    end
                end
            end

            assign com_s = com_pipe_q[SYNC_STAGES-1];
            assign seg_s = seg_pipe_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [3:0] dec_nib;
    logic       dec_err;

    seg7_pattern_decode u_decode (
        .seg    (seg_s),
        .nibble (dec_nib),
        .err    (dec_err)
    );

    fnd_state_e    state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [3:0]    cap_com_q, cap_com_d;
    logic [6:0]    cap_seg_q, cap_seg_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    com_last_q;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   shadow_nib_q, shadow_nib_d;
    logic [3:0]    shadow_err_q, shadow_err_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   value_q, value_d;
    logic [3:0]    digit_err_q, digit_err_d;
    logic          frame_err_q, frame_err_d;
    logic          frame_valid_q, frame_valid_d;
    logic          changed_q, changed_d;
    logic          stall_q, stall_d;

    com_sel_t sel;
    logic     enter;
    logic     publish;
    logic     stall_evt;

    assign sel = decode_com(com_s);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_com_d     = cap_com_q;
        cap_seg_d     = cap_seg_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        shadow_nib_d  = shadow_nib_q;
        shadow_err_d  = shadow_err_q;
        mask_d        = mask_q;
        value_d       = value_q;
        digit_err_d   = digit_err_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;
        changed_d     = 1'b0;
        stall_d       = stall_q;
        enter         = 1'b0;
        publish       = 1'b0;
        stall_evt     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel.valid) enter = 1'b1;
            end
            SETTLE: begin
                if (com_s != cap_com_q) begin
                    if (sel.valid) enter = 1'b1;
                    else           state_d = IDLE;
                end else if (seg_s != cap_seg_q) begin
                    cap_seg_d = seg_s;
                    cnt_d     = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    shadow_nib_d[{idx_q, 2'b00} +: 4] = dec_nib;
                    shadow_err_d[idx_q]               = dec_err;
                    mask_d[idx_q]                     = 1'b1;
                    state_d                           = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (com_s != cap_com_q) begin
                    if (sel.valid) enter = 1'b1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter) begin
            state_d   = SETTLE;
            cnt_d     = '0;
            cap_com_d = com_s;
            cap_seg_d = seg_s;
            idx_d     = sel.idx;
        end

        // A new digit-3 entry with all four digits captured closes the previous sweep.
        publish = enter && (sel.idx == 2'd3) && (mask_q == 4'hF);

        if (com_s != com_last_q) begin
            tmo_d   = '0;
            stall_d = 1'b0;
        end else if (tmo_q == TIMEOUT_LAST) begin
            stall_evt = !stall_q;
            stall_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (stall_evt) begin
            mask_d = '0;
        end else if (publish) begin
            value_d       = shadow_nib_q;
            digit_err_d   = shadow_err_q;
            frame_err_d   = |shadow_err_q;
            frame_valid_d = 1'b1;
            changed_d     = (shadow_nib_q != value_q);
            mask_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cap_com_q     <= 4'hF;
            cap_seg_q     <= SEG_BLANK;
            idx_q         <= '0;
            com_last_q    <= 4'hF;
            tmo_q         <= '0;
            shadow_nib_q  <= '0;
            shadow_err_q  <= '0;
            mask_q        <= '0;
            value_q       <= '0;
            digit_err_q   <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cap_com_q     <= cap_com_d;
            cap_seg_q     <= cap_seg_d;
            idx_q         <= idx_d;
            com_last_q    <= com_s;
            tmo_q         <= tmo_d;
            shadow_nib_q  <= shadow_nib_d;
            shadow_err_q  <= shadow_err_d;
            mask_q        <= mask_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            stall_q       <= stall_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign digit_err   = digit_err_q;
    assign changed     = changed_q;
    assign scan_stall  = stall_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb/tb_fnd_scan_decoder.sv - scoreboard bench for fnd_scan_decoder with a sweep-level reference model
module tb_fnd_scan_decoder;

    localparam int TMO = 100;

    localparam logic [6:0] ENC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [15:0] v;
        logic [3:0]  de;
        logic        fe;
        logic        ch;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [3:0]  com;
    logic [7:0]  seg_7;
    logic [15:0] value;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  digit_err;
    logic        changed;
    logic        scan_stall;

    int n_cmp = 0;
    int n_err = 0;

    frame_t      exp_q [$];
    logic [3:0]  cap_nib [4];
    logic [3:0]  cap_err;
    logic [3:0]  capmask;
    logic [15:0] last_pub;

    fnd_scan_decoder #(
        .SYNC_STAGES (2),
        .SETTLE_CYC  (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .com         (com),
        .seg_7       (seg_7),
        .value       (value),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .digit_err   (digit_err),
        .changed     (changed),
        .scan_stall  (scan_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n, output logic e);
        n = 4'd0;
        e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (ENC[i] == p) begin
                n = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    function automatic logic [6:0] bad_pattern();
        logic [6:0] p;
        logic [3:0] n;
        logic       e;
        do begin
            p = 7'($urandom);
            ref_decode(p, n, e);
        end while (!e);
        return p;
    endfunction

    // Model: a completed sweep is published when the next digit-3 drive begins.
    task automatic model_publish();
        frame_t f;
        f.v  = {cap_nib[3], cap_nib[2], cap_nib[1], cap_nib[0]};
        f.de = cap_err;
        f.fe = |cap_err;
        f.ch = (f.v != last_pub);
        last_pub = f.v;
        capmask  = 4'h0;
        exp_q.push_back(f);
    endtask

    task automatic gap(input int n);
        logic [3:0] g;
        g = 4'($urandom);
        if (g == 4'b1110 || g == 4'b1101 || g == 4'b1011 || g == 4'b0111) g = 4'hF;
        com   = g;
        seg_7 = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_digit(input int d, input logic [6:0] pat, input int dwell, input bit glitch);
        logic [3:0] c;
        logic [3:0] n;
        logic       e;
        c    = 4'hF;
        c[d] = 1'b0;
        if (d == 3 && capmask == 4'hF) model_publish();
        com   = c;
        seg_7 = {1'($urandom), pat};
        for (int i = 0; i < dwell; i++) begin
            @(negedge clk);
            seg_7[7] = 1'($urandom);
            if (glitch && i == 3) seg_7[6:0] = pat ^ 7'($urandom_range(1, 127));
            if (glitch && i == 8) seg_7[6:0] = pat;
        end
        ref_decode(pat, n, e);
        cap_nib[d] = n;
        cap_err[d] = e;
        capmask[d] = 1'b1;
    endtask

    task automatic sweep(input logic [15:0] v, input logic [3:0] bad, input bit blank,
                         input int glitch_d, input bit allow_rep);
        logic [6:0] p;
        for (int k = 3; k >= 0; k--) begin
            p = bad[k] ? (blank ? 7'h7F : bad_pattern()) : ENC[v[4*k +: 4]];
            if (allow_rep && (k == 1 || k == 2) && $urandom_range(0, 3) == 0) begin
                drive_digit(k, ENC[$urandom_range(0, 15)], $urandom_range(30, 60), 1'b0);
                gap(2);
            end
            drive_digit(k, p, $urandom_range(30, 60), (k == glitch_d));
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 4));
        end
    endtask

    task automatic random_sweep();
        logic [3:0] bad;
        bad = 4'h0;
        for (int j = 0; j < 4; j++) if ($urandom_range(0, 7) == 0) bad[j] = 1'b1;
        sweep(16'($urandom), bad, 1'($urandom), $urandom_range(0, 5), 1'b1);
    endtask

    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: got value %0h expected no frame", value);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_value", 32'(value), 32'(f.v));
                    check("frame_digit_err", 32'(digit_err), 32'(f.de));
                    check("frame_err", 32'(frame_err), 32'(f.fe));
                    check("frame_changed", 32'(changed), 32'(f.ch));
                end
            end
        end
    end

    initial begin
        capmask  = 4'h0;
        cap_err  = 4'h0;
        last_pub = 16'h0;
        for (int i = 0; i < 4; i++) cap_nib[i] = 4'h0;
        reset_p = 1'b0;
        com     = 4'hF;
        seg_7   = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_value", 32'(value), 32'h0);
        check("reset_frame_valid", 32'(frame_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_digit_err", 32'(digit_err), 32'h0);
        check("reset_changed", 32'(changed), 32'h0);
        check("reset_scan_stall", 32'(scan_stall), 32'h0);
        reset_p = 1'b1;
        gap(5);

        sweep(16'h1234, 4'h0, 1'b0, -1, 1'b0);
        sweep(16'h1234, 4'h0, 1'b0, -1, 1'b0);
        sweep(16'h1234, 4'h0, 1'b0, -1, 1'b0);
        sweep(16'hFFFF, 4'b0100, 1'b1, -1, 1'b0);
        sweep(16'($urandom), 4'h0, 1'b0, 1, 1'b0);
        for (int s = 0; s < 20; s++) random_sweep();

        // Static com for longer than the timeout.
        gap(3);
        com   = 4'b1110;
        seg_7 = {1'b0, ENC[5]};
        repeat (95) @(negedge clk);
        check("stall_early", 32'(scan_stall), 32'h0);
        repeat (13) @(negedge clk);
        check("stall_set", 32'(scan_stall), 32'h1);
        check("stall_value_kept", 32'(value), 32'(last_pub));
        repeat (40) @(negedge clk);
        capmask = 4'h0;
        gap(4);
        check("stall_clear", 32'(scan_stall), 32'h0);
        for (int s = 0; s < 4; s++) random_sweep();

        // Reset in the middle of a sweep after three digits.
        drive_digit(3, ENC[$urandom_range(0, 15)], 40, 1'b0);
        drive_digit(2, ENC[$urandom_range(0, 15)], 40, 1'b0);
        drive_digit(1, ENC[$urandom_range(0, 15)], 40, 1'b0);
        @(negedge clk);
        reset_p = 1'b0;
        #1;
        check("midreset_value", 32'(value), 32'h0);
        check("midreset_frame_valid", 32'(frame_valid), 32'h0);
        check("midreset_digit_err", 32'(digit_err), 32'h0);
        check("midreset_frame_err", 32'(frame_err), 32'h0);
        check("midreset_scan_stall", 32'(scan_stall), 32'h0);
        capmask  = 4'h0;
        last_pub = 16'h0;
        repeat (3) @(negedge clk);
        reset_p = 1'b1;
        gap(4);
        for (int s = 0; s < 4; s++) random_sweep();

        drive_digit(3, ENC[0], 40, 1'b0);
        gap(10);
        check("all_frames_seen", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
